// File: rtl/fp_pkg.sv
// Shared constants, state encoding and operand unpack helper for the
// single-precision multiply front end.
package fp_pkg;

  localparam int MANT_W = 23;
  localparam int EXP_W  = 8;
  localparam int BIAS   = 127;
  localparam int CNT_W  = 5;
  localparam int ACC_W  = 2 * (MANT_W + 1);

  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [CNT_W-1:0] LAST_CNT = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_NORM = 2'd2
  } state_t;

  // Denormals are flushed to zero, so only a nonzero exponent gets the hidden bit.
  function automatic logic [MANT_W:0] unpack_mant(input logic [31:0] op);
    if (op[30:23] == 8'h00) begin
      return {(MANT_W + 1){1'b0}};
    end else begin
      return {1'b1, op[MANT_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/fp_mant_seq_mult.sv
// 24x24 shift-add mantissa multiplier: one partial product per step,
// multiplier bit selected by the iteration counter.
module fp_mant_seq_mult
  import fp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [MANT_W:0]    i_mcand,
  input  logic [MANT_W:0]    i_mplier,
  output logic [ACC_W-1:0]   o_acc,
  output logic [CNT_W-1:0]   o_cnt
);

  logic [MANT_W:0]  r_mcand;
  logic [MANT_W:0]  r_mplier;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] w_pp;

  assign w_pp = {{(MANT_W + 1){1'b0}}, r_mcand} << r_cnt;

  // Operand capture on load, then accumulate one shifted partial product per step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand  <= {(MANT_W + 1){1'b0}};
      r_mplier <= {(MANT_W + 1){1'b0}};
      r_acc    <= {ACC_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_acc    <= {ACC_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else if (i_step) begin
      if (r_mplier[r_cnt]) begin
        r_acc <= r_acc + w_pp;
      end
      r_cnt <= r_cnt + 5'd1;
    end
  end

  assign o_acc = r_acc;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/fp_mul_normalize.sv
// Multi-cycle single-precision multiply front end: unpack, sequential mantissa
// multiply, then normalise and produce the biased exponent and exception flags.
module fp_mul_normalize
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [24:0] final_product,
  output logic [8:0]  final_exponent,
  output logic        new_sign,
  output logic        exception1,
  output logic        exception2
);

  state_t r_state;
  state_t w_next;

  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_busy;
  logic             r_done;
  logic [24:0]      r_product;
  logic [8:0]       r_exponent;
  logic             r_sign;
  logic             r_exc1;
  logic             r_exc2;

  logic             w_load;
  logic             w_step;
  logic [ACC_W-1:0] w_acc;
  logic [CNT_W-1:0] w_cnt;

  logic [EXP_W-1:0] w_ea;
  logic [EXP_W-1:0] w_eb;
  logic             w_zero;
  logic             w_exc1;
  logic             w_up;
  logic [9:0]       w_e_u;
  logic signed [9:0] w_e;
  logic [24:0]      w_product;
  logic [8:0]       w_exponent;
  logic             w_exc2_raw;
  logic             w_exc2;

  assign w_load = (r_state == ST_IDLE) && start;
  assign w_step = (r_state == ST_MULT);

  fp_mant_seq_mult u_mult (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_mcand  (unpack_mant(a)),
    .i_mplier (unpack_mant(b)),
    .o_acc    (w_acc),
    .o_cnt    (w_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start outside IDLE is simply dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_MULT;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_MULT: begin
        if (w_cnt == LAST_CNT) begin
          w_next = ST_NORM;
        end else begin
          w_next = ST_MULT;
        end
      end
      ST_NORM: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_ea   = r_a[30:23];
  assign w_eb   = r_b[30:23];
  assign w_zero = (w_ea == 8'h00) || (w_eb == 8'h00);
  assign w_exc1 = (w_ea == EXP_MAX) || (w_eb == EXP_MAX);
  assign w_up   = w_acc[ACC_W-1];
  assign w_e_u  = {2'b00, w_ea} + {2'b00, w_eb} + {9'd0, w_up} - 10'(BIAS);
  assign w_e    = $signed(w_e_u);

  // Normalise, saturate the exponent and resolve the exception flags.
  always_comb begin
    w_product  = 25'd0;
    w_exponent = 9'd0;
    w_exc2_raw = 1'b0;
    if (w_zero) begin
      w_product  = 25'd0;
      w_exponent = 9'd0;
      w_exc2_raw = 1'b0;
    end else begin
      if (w_up) begin
        w_product = {1'b0, w_acc[47:24]};
      end else begin
        w_product = {1'b0, w_acc[46:23]};
      end
      if (w_e >= 10'sd255) begin
        w_exponent = 9'h0FF;
        w_exc2_raw = 1'b1;
      end else if (w_e <= 10'sd0) begin
        w_exponent = 9'h000;
        w_exc2_raw = 1'b1;
      end else begin
        w_exponent = {1'b0, w_e_u[7:0]};
        w_exc2_raw = 1'b0;
      end
    end
    if (w_exc1) begin
      w_exc2 = 1'b0;
    end else begin
      w_exc2 = w_exc2_raw;
    end
  end

  // Operand latch; exponents and signs are read back during NORM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= 32'd0;
      r_b <= 32'd0;
    end else if (w_load) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Handshake flags and result registers; results only move on the NORM edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_product  <= 25'd0;
      r_exponent <= 9'd0;
      r_sign     <= 1'b0;
      r_exc1     <= 1'b0;
      r_exc2     <= 1'b0;
    end else begin
      r_busy <= (r_state == ST_MULT);
      r_done <= (r_state == ST_NORM);
      if (r_state == ST_NORM) begin
        r_product  <= w_product;
        r_exponent <= w_exponent;
        r_sign     <= r_a[31] ^ r_b[31];
        r_exc1     <= w_exc1;
        r_exc2     <= w_exc2;
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign final_product  = r_product;
  assign final_exponent = r_exponent;
  assign new_sign       = r_sign;
  assign exception1     = r_exc1;
  assign exception2     = r_exc2;

endmodule

// File: tb/tb_fp_mul_normalize.sv
// Directed self-checking bench for fp_mul_normalize: handshake timing,
// normalisation, exponent saturation, exceptions, ignored start and reset abort.
module tb_fp_mul_normalize;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [24:0] final_product;
  logic [8:0]  final_exponent;
  logic        new_sign;
  logic        exception1;
  logic        exception2;

  int total = 0;
  int bad   = 0;

  fp_mul_normalize dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .a              (a),
    .b              (b),
    .busy           (busy),
    .done           (done),
    .final_product  (final_product),
    .final_exponent (final_exponent),
    .new_sign       (new_sign),
    .exception1     (exception1),
    .exception2     (exception2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [24:0] p, input logic [8:0] e,
                         input logic s, input logic x1, input logic x2);
    chk({tag, "_product"}, {39'd0, final_product}, {39'd0, p});
    chk({tag, "_exponent"}, {55'd0, final_exponent}, {55'd0, e});
    chk({tag, "_flags"}, {61'd0, new_sign, exception1, exception2}, {61'd0, s, x1, x2});
  endtask

  // Runs one operation; the done cycle is left current on return unless aborted.
  task automatic do_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input int poke_at, input int abort_at);
    logic [24:0] hold_p;
    int errs;
    errs = 0;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    hold_p = final_product;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy !== 1'b0 || done !== 1'b0) errs++;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1 || done !== 1'b0 || final_product !== hold_p) errs++;
      if (i == poke_at) begin
        start = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
      end else begin
        start = 1'b0;
      end
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        chk({tag, "_abort_clear"},
            {25'd0, busy, done, final_product, final_exponent, new_sign, exception1, exception2},
            64'd0);
        return;
      end
    end
    chk({tag, "_busy_window"}, 64'(errs), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {62'd0, busy, done}, 64'd1);
  endtask

  initial begin
    int dones;
    reset = 1'b0; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        {25'd0, busy, done, final_product, final_exponent, new_sign, exception1, exception2},
        64'd0);
    @(negedge clk); reset = 1'b1;

    do_op("mul_1p5x2", 32'h3FC00000, 32'h40000000, -1, -1);
    chk_res("mul_1p5x2", 25'h0C00000, 9'h080, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done_clears", {63'd0, done}, 64'd0);
    chk("outputs_hold", {39'd0, final_product}, {39'd0, 25'h0C00000});

    do_op("mul_1p5xm1p5", 32'h3FC00000, 32'hBFC00000, -1, -1);
    chk_res("mul_1p5xm1p5", 25'h0900000, 9'h080, 1'b1, 1'b0, 1'b0);

    do_op("mul_negzero", 32'h80000000, 32'h40490FDB, -1, -1);
    chk_res("mul_negzero", 25'h0000000, 9'h000, 1'b1, 1'b0, 1'b0);

    do_op("mul_inf", 32'h7F800000, 32'h3F800000, -1, -1);
    chk("mul_inf_exc", {62'd0, exception1, exception2}, 64'd2);

    do_op("mul_ovf", 32'h7F000000, 32'h40000000, -1, -1);
    chk("mul_ovf_exc2", {63'd0, exception2}, 64'd1);
    chk("mul_ovf_exp", {55'd0, final_exponent}, {55'd0, 9'h0FF});

    do_op("mul_unf", 32'h00800000, 32'h3F000000, -1, -1);
    chk("mul_unf_exc2", {63'd0, exception2}, 64'd1);
    chk("mul_unf_exp", {55'd0, final_exponent}, 64'd0);

    do_op("start_ignored", 32'h3FC00000, 32'h40000000, 5, -1);
    chk_res("start_ignored", 25'h0C00000, 9'h080, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("start_ignored_no_done", {62'd0, busy, done}, 64'd0);

    do_op("abort", 32'h3FC00000, 32'hBFC00000, -1, 10);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_idle_busy", {63'd0, busy}, 64'd0);

    do_op("mul_1x1", 32'h3F800000, 32'h3F800000, -1, -1);
    chk_res("mul_1x1", 25'h0800000, 9'h07F, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
